axi_master_rd: RTL and testbench

- AXI read-side initiator; the counterpart of the team's AXI read slave.
- Accepts one burst command at a time from a local client and issues it on the read address channel (AR).
- Collects the read data beats (R) into a local FIFO and streams them to the client.
- Reports completion with an accumulated response and a protocol-error flag.
- Sits between internal DMA/test logic and the AXI fabric.

---
 rtl/axi_master_rd.sv | 159 +++++++++++++++
 tb/tb_axi_master_rd.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_rd.sv
// AXI read initiator: takes one burst command from a local client, issues it on AR,
// buffers the returned R beats in a first-word-fall-through FIFO and reports completion.
module axi_master_rd #(
  parameter int ADDR_BITS  = 32,
  parameter int LEN_BITS   = 8,
  parameter int SIZE_BITS  = 3,
  parameter int DATA_BITS  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic [SIZE_BITS-1:0] cmd_size,
  input  logic [1:0]           cmd_burst,
  input  logic                 ar_ready,
  output logic [ADDR_BITS-1:0] ar_addr,
  output logic [LEN_BITS-1:0]  ar_len,
  output logic [SIZE_BITS-1:0] ar_size,
  output logic [1:0]           ar_burst,
  output logic [3:0]           ar_cache,
  output logic                 ar_valid,
  output logic                 r_ready,
  input  logic [DATA_BITS-1:0] r_data,
  input  logic                 r_valid,
  input  logic                 r_last,
  input  logic [1:0]           r_resp,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_last,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 done,
  output logic [1:0]           done_resp,
  output logic                 done_err
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam logic [1:0] BURST_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state, state_nxt;
  logic [LEN_BITS-1:0]   beat_cnt;
  logic [1:0]            resp_acc, resp_nxt;
  logic                  err_acc, err_nxt;
  logic                  cmd_fire, r_fire, pop, full, beat_final;

  logic [DATA_BITS:0]    mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [PTR_BITS:0]     count;

  assign ar_cache   = 4'b0011;
  assign full       = count[PTR_BITS];
  assign rd_valid   = (count != '0);
  assign rd_data    = mem[rd_ptr][DATA_BITS:1];
  assign rd_last    = mem[rd_ptr][0];
  assign pop        = rd_valid && rd_ready;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign r_fire     = r_valid && r_ready;
  assign beat_final = (beat_cnt == ar_len);
  // Responses rank by code value, so the worst response is a plain maximum.
  assign resp_nxt   = (r_resp > resp_acc) ? r_resp : resp_acc;
  assign err_nxt    = err_acc || (r_last != beat_final);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_nxt = state;
    cmd_ready = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    case (state)
      IDLE: begin
        // Hold off the next command during the done pulse.
        cmd_ready = !done;
        if (cmd_valid && !done && cmd_burst != BURST_RSVD) state_nxt = ADDR;
      end
      ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nxt = DATA;
      end
      DATA: begin
        r_ready = !full || pop;
        if (r_valid && r_ready && beat_final) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      ar_addr   <= '0;
      ar_len    <= '0;
      ar_size   <= '0;
      ar_burst  <= '0;
      beat_cnt  <= '0;
      resp_acc  <= '0;
      err_acc   <= 1'b0;
      done      <= 1'b0;
      done_resp <= '0;
      done_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (cmd_fire) begin
        if (cmd_burst == BURST_RSVD) begin
          done      <= 1'b1;
          done_resp <= 2'b10;
          done_err  <= 1'b0;
        end else begin
          ar_addr  <= cmd_addr;
          ar_len   <= cmd_len;
          ar_size  <= cmd_size;
          ar_burst <= cmd_burst;
        end
      end
      if (ar_valid && ar_ready) begin
        beat_cnt <= '0;
        resp_acc <= '0;
        err_acc  <= 1'b0;
      end
      if (r_fire) begin
        beat_cnt <= beat_cnt + 1'b1;
        resp_acc <= resp_nxt;
        err_acc  <= err_nxt;
        if (beat_final) begin
          done      <= 1'b1;
          done_resp <= resp_nxt;
          done_err  <= err_nxt;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (r_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({r_fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge aclk) begin
    if (r_fire) mem[wr_ptr] <= {r_data, beat_final};
  end

endmodule

// File: tb/tb_axi_master_rd.sv
// Directed and randomized bench for axi_master_rd with a behavioural slave/client model
// and a beat-list scoreboard.
module tb_axi_master_rd;
  localparam int AW = 32, LW = 8, SW = 3, DW = 32, DEPTH = 16;

  logic          aclk = 1'b0, areset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [SW-1:0] cmd_size = '0;
  logic [1:0]    cmd_burst = '0;
  logic          ar_ready = 1'b1, ar_valid;
  logic [AW-1:0] ar_addr;
  logic [LW-1:0] ar_len;
  logic [SW-1:0] ar_size;
  logic [1:0]    ar_burst;
  logic [3:0]    ar_cache;
  logic          r_ready, r_valid = 1'b0, r_last = 1'b0;
  logic [DW-1:0] r_data = '0;
  logic [1:0]    r_resp = '0;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_valid, rd_ready = 1'b0;
  logic          done, done_err;
  logic [1:0]    done_resp;

  axi_master_rd #(.ADDR_BITS(AW), .LEN_BITS(LW), .SIZE_BITS(SW), .DATA_BITS(DW),
                  .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_cache(ar_cache), .ar_valid(ar_valid),
    .r_ready(r_ready), .r_data(r_data), .r_valid(r_valid), .r_last(r_last), .r_resp(r_resp),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .done_err(done_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0, errors = 0, cyc = 0;
  // Slave beat list for the current burst and the traffic rates of slave and client.
  logic [DW-1:0] b_data[$];
  logic [1:0]    b_resp[$];
  logic          b_last[$];
  int sidx = 0, r_rate = 100, rd_rate = 100;
  bit slave_go = 0, cmd_hs = 0;
  // Observations collected each cycle.
  logic [DW:0]   got_q[$];
  int ar_hs, ar_cycles, r_hs_cnt, done_cnt, done_cyc, last_r_cyc;
  logic [1:0]    got_resp;
  logic          got_err;
  logic [AW-1:0] seen_addr, exp_addr;
  logic [LW-1:0] seen_len;
  logic [SW-1:0] seen_size, exp_size;
  logic [1:0]    seen_burst, exp_burst;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe settled outputs at the falling edge, then drive new inputs after the rise.
  task automatic cycle();
    bit r_hs;
    @(negedge aclk);
    cyc++;
    r_hs   = r_valid && r_ready;
    cmd_hs = cmd_hs || (cmd_valid && cmd_ready);
    if (ar_valid) ar_cycles++;
    if (ar_valid && ar_ready) begin
      ar_hs++;
      seen_addr = ar_addr; seen_len = ar_len; seen_size = ar_size; seen_burst = ar_burst;
      slave_go = 1;
    end
    if (r_hs) begin r_hs_cnt++; last_r_cyc = cyc; end
    if (rd_valid && rd_ready) got_q.push_back({rd_data, rd_last});
    if (done) begin done_cnt++; done_cyc = cyc; got_resp = done_resp; got_err = done_err; end
    @(posedge aclk); #1;
    if (r_hs) sidx++;
    if (!(r_valid && !r_hs))
      r_valid = slave_go && (sidx < b_data.size()) && ($urandom_range(99) < r_rate);
    if (sidx < b_data.size()) begin
      r_data = b_data[sidx]; r_resp = b_resp[sidx]; r_last = b_last[sidx];
    end
    rd_ready = ($urandom_range(99) < rd_rate);
  endtask

  task automatic gen_beats(input int len, input bit rand_last);
    b_data.delete(); b_resp.delete(); b_last.delete();
    for (int i = 0; i <= len; i++) begin
      b_data.push_back($urandom);
      b_resp.push_back(2'($urandom_range(3)));
      b_last.push_back(rand_last ? 1'($urandom_range(1)) : (i == len));
    end
    sidx = 0; slave_go = 0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input logic [SW-1:0] s, input logic [1:0] b);
    got_q.delete();
    ar_hs = 0; ar_cycles = 0; r_hs_cnt = 0; done_cnt = 0; done_cyc = -1; last_r_cyc = -1;
    exp_addr = a; exp_size = s; exp_burst = b;
    cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_valid = 1'b1;
    cmd_hs = 0;
    for (int k = 0; k < 50 && !cmd_hs; k++) cycle();
    cmd_valid = 1'b0;
    check("cmd_accept", 64'(cmd_hs), 1);
  endtask

  // Expected outcome from the beat list: data in order, last on beat len, worst response,
  // error if any r_last disagrees with the counted final beat.
  task automatic finish_burst(input string tag);
    int n = b_data.size();
    logic [1:0] er = 2'b00;
    bit ee = 0;
    for (int i = 0; i < n; i++) begin
      if (b_resp[i] > er) er = b_resp[i];
      if (b_last[i] != (i == n - 1)) ee = 1;
    end
    for (int k = 0; k < 4000 && !(done_cnt > 0 && got_q.size() >= n); k++) cycle();
    repeat (3) cycle();
    check({tag, "_ar_hs"}, ar_hs, 1);
    check({tag, "_ar_addr"}, seen_addr, exp_addr);
    check({tag, "_ar_len"}, seen_len, n - 1);
    check({tag, "_ar_size"}, seen_size, exp_size);
    check({tag, "_ar_burst"}, seen_burst, exp_burst);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_lat"}, done_cyc, last_r_cyc + 1);
    check({tag, "_done_resp"}, got_resp, er);
    check({tag, "_done_err"}, 64'(got_err), 64'(ee));
    check({tag, "_beats"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got_q[i], {b_data[i], (i == n - 1)});
  endtask

  initial begin
    repeat (2) @(posedge aclk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ar_valid", ar_valid, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_done_err", done_err, 0);
    check("rst_done_resp", done_resp, 0);
    check("rst_ar_addr", ar_addr, 0);
    check("rst_ar_len", ar_len, 0);
    check("ar_cache", ar_cache, 4'b0011);
    areset_n = 1'b1;
    cycle();

    // Basic INCR burst, data A0..A3, all OKAY.
    gen_beats(3, 0);
    for (int i = 0; i < 4; i++) begin b_data[i] = 32'hA0 + i; b_resp[i] = 2'b00; end
    issue(32'h1000, 3, 2, 2'b01);
    finish_burst("t1");
    check("t1_ar_cycles", ar_cycles, 1);

    // Address held stable while the slave stalls AR for 5 cycles.
    ar_ready = 1'b0;
    gen_beats(2, 0);
    issue(32'h2000, 2, 2, 2'b01);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_ar_valid%0d", k), ar_valid, 1);
      check($sformatf("t2_ar_addr%0d", k), ar_addr, 32'h2000);
      check($sformatf("t2_cmd_ready%0d", k), cmd_ready, 0);
      if (k == 5) ar_ready = 1'b1;
      cycle();
    end
    finish_burst("t2");
    check("t2_ar_cycles", ar_cycles, 6);

    // FIFO backpressure: 20 beats with the client stalled.
    gen_beats(19, 0);
    rd_rate = 0;
    issue(32'h3000, 19, 2, 2'b01);
    repeat (30) cycle();
    check("t3_beats_taken", r_hs_cnt, DEPTH);
    check("t3_r_ready_full", r_ready, 0);
    check("t3_rd_valid", rd_valid, 1);
    rd_rate = 100;
    finish_burst("t3");

    // Response accumulation: OKAY, SLVERR, DECERR.
    gen_beats(2, 0);
    b_resp[0] = 2'b00; b_resp[1] = 2'b10; b_resp[2] = 2'b11;
    issue(32'h4000, 2, 2, 2'b01);
    finish_burst("t4");
    check("t4_decerr", got_resp, 2'b11);

    // Early r_last, then a missing r_last.
    gen_beats(3, 0);
    b_last[0] = 0; b_last[1] = 1; b_last[2] = 0; b_last[3] = 1;
    issue(32'h5000, 3, 2, 2'b01);
    finish_burst("t5a");
    check("t5a_err", got_err, 1);
    gen_beats(1, 0);
    b_last[0] = 0; b_last[1] = 0;
    issue(32'h5100, 1, 2, 2'b01);
    finish_burst("t5b");
    check("t5b_err", got_err, 1);

    // Reserved burst type: no AR, immediate SLVERR completion.
    gen_beats(0, 0);
    b_data.delete(); b_resp.delete(); b_last.delete();
    issue(32'h6000, 5, 2, 2'b11);
    check("t6_done", done, 1);
    check("t6_done_resp", done_resp, 2'b10);
    check("t6_done_err", done_err, 0);
    check("t6_ar_valid", ar_valid, 0);
    check("t6_cmd_ready_during_done", cmd_ready, 0);
    repeat (4) cycle();
    check("t6_done_cnt", done_cnt, 1);
    check("t6_ar_cycles", ar_cycles, 0);
    check("t6_cmd_ready_after", cmd_ready, 1);

    // Reset in the middle of a data phase.
    gen_beats(7, 0);
    rd_rate = 0;
    issue(32'h7000, 7, 2, 2'b01);
    repeat (5) cycle();
    areset_n = 1'b0;
    slave_go = 0; r_valid = 1'b0; rd_rate = 100;
    #1;
    check("t7_cmd_ready", cmd_ready, 1);
    check("t7_ar_valid", ar_valid, 0);
    check("t7_r_ready", r_ready, 0);
    check("t7_rd_valid", rd_valid, 0);
    check("t7_done", done, 0);
    check("t7_done_resp", done_resp, 0);
    check("t7_ar_addr", ar_addr, 0);
    repeat (2) cycle();
    check("t7_no_done", done_cnt, 0);
    areset_n = 1'b1;
    cycle();
    check("t7_fifo_empty", rd_valid, 0);
    gen_beats(4, 0);
    issue(32'h7100, 4, 1, 2'b10);
    finish_burst("t7");

    // Randomized bursts, lengths across the FIFO depth, random rates and r_last faults.
    for (int t = 0; t < 10; t++) begin
      int len = $urandom_range(40);
      r_rate  = $urandom_range(100, 30);
      rd_rate = $urandom_range(100, 30);
      gen_beats(len, $urandom_range(3) == 0);
      issue($urandom, LW'(len), SW'($urandom_range(5)), 2'($urandom_range(2)));
      finish_burst($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
